// File: rtl/load_store_unit_if.sv
// Data-bus interface of the load/store unit.
// One valid/ready beat per access. The master holds valid/we/addr/be/wdata stable until ready.
//   valid  master->slave  bus request
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte enables
//   wdata  master->slave  lane-replicated store data
//   ready  slave->master  beat accepted/completed
//   rdata  slave->master  read data, valid with ready
//   err    slave->master  bus error, valid with ready
interface load_store_unit_if;
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, we, addr, be, wdata,
        input  ready, rdata, err
    );

    modport slave (
        input  valid, we, addr, be, wdata,
        output ready, rdata, err
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit.
// Runs one data-bus beat for each memory-stage access. It generates byte enables and
// replicated store data, formats load data, and stalls the pipeline until the access completes.
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   req_valid       memory stage holds a load/store
//   req_we          1 = store, 0 = load
//   req_funct3      RV32I width/sign code
//   req_addr        byte address
//   req_wdata       store data
//   stall_req       hold all pipeline stages (combinational)
//   done            one-cycle completion pulse
//   rdata_out       formatted load data
//   access_fault    completion faulted (valid with done)
//   fault_misalign  fault cause was misalignment (valid with done)
//   bus             data-bus master port (load_store_unit_if.master)
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
// When it is undefined, the low address bits of such accesses are ignored.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall_req,
    output logic              done,
    output logic [31:0]       rdata_out,
    output logic              access_fault,
    output logic              fault_misalign,
    load_store_unit_if.master bus
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBus, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        mis_q, mis_d;

    logic        req_legal;
    logic        req_misalign;
    logic [3:0]  req_be;
    logic [31:0] req_wrep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_fmt;

    always_comb begin
        req_legal = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !req_we;
            default:                req_legal = 1'b0;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misalign = req_legal &
                          (((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                           ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0])));
`else
    assign req_misalign = 1'b0;
`endif

    // Byte/half lanes use only the address bits that matter, so misaligned accesses are
    // aligned automatically when trapping is disabled.
    always_comb begin
        req_be   = 4'b1111;
        req_wrep = req_wdata;
        unique case (req_funct3[1:0])
            2'b00: begin
                req_be   = 4'b0001 << req_addr[1:0];
                req_wrep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be   = 4'b0011 << {req_addr[1], 1'b0};
                req_wrep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_be   = 4'b1111;
                req_wrep = req_wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = bus.rdata[7:0];
        case (lane_q)
            2'd0: ld_byte = bus.rdata[7:0];
            2'd1: ld_byte = bus.rdata[15:8];
            2'd2: ld_byte = bus.rdata[23:16];
            2'd3: ld_byte = bus.rdata[31:24];
            default: ld_byte = bus.rdata[7:0];
        endcase
        ld_half = lane_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        ld_fmt  = bus.rdata;
        unique case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = bus.rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        mis_d    = mis_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    addr_d   = {req_addr[31:2], 2'b00};
                    be_d     = req_be;
                    wdata_d  = req_wrep;
                    funct3_d = req_funct3;
                    lane_d   = req_addr[1:0];
                    cnt_d    = '0;
                    if (!req_legal || req_misalign) begin
                        // Fault without touching the bus.
                        state_d = StDone;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        mis_d   = req_misalign;
                        if (!req_we) rdata_d = '0;
                    end else begin
                        state_d = StBus;
                        valid_d = 1'b1;
                    end
                end
            end
            StBus: begin
                if (bus.ready) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    fault_d = bus.err;
                    if (!we_q) rdata_d = bus.err ? '0 : ld_fmt;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                // The request is still visible here; it has already been served.
                state_d = StIdle;
                fault_d = 1'b0;
                mis_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            mis_q    <= mis_d;
        end
    end

    assign stall_req      = ((state_q == StIdle) & req_valid) | (state_q == StBus);
    assign done           = done_q;
    assign rdata_out      = rdata_q;
    assign access_fault   = fault_q;
    assign fault_misalign = mis_q;
    assign bus.valid      = valid_q;
    assign bus.we         = we_q;
    assign bus.addr       = addr_q;
    assign bus.be         = be_q;
    assign bus.wdata      = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit.
// Expected completions go into a scoreboard queue and are checked when done pulses.
// A second instance with TIMEOUT_CYCLES=4 covers the bus timeout.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall_req, done, access_fault, fault_misalign;
    logic [31:0] rdata_out;
    logic        stall_b, done_b, fault_b, mis_b;
    logic [31:0] rdata_b;

    load_store_unit_if busa();
    load_store_unit_if busb();

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_req(stall_req), .done(done), .rdata_out(rdata_out),
        .access_fault(access_fault), .fault_misalign(fault_misalign), .bus(busa.master)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall_req(stall_b), .done(done_b), .rdata_out(rdata_b),
        .access_fault(fault_b), .fault_misalign(mis_b), .bus(busb.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle. The bus answers in BUS cycle delay+1.
    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                          input logic [31:0] brdata, input logic berr, input bit uses_bus,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                          input logic e_fault, input logic e_mis);
        exp_t e;
        int   cyc, busc, stalls, exp_busc;
        bit   got;
        e.rdata = e_rdata;
        e.fault = e_fault;
        e.mis   = e_mis;
        sb.push_back(e);
        exp_busc   = uses_bus ? delay + 1 : 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        busa.ready = 1'b0;
        busa.rdata = brdata;
        busa.err   = berr;
        #1;
        stalls = stall_req ? 1 : 0;
        cyc    = 0;
        busc   = 0;
        got    = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got = 1;
            end else begin
                busc++;
                if (stall_req) stalls++;
                check({tag, ".bus_valid"}, 32'(busa.valid), 32'd1);
                check({tag, ".bus_addr"}, busa.addr, e_addr);
                check({tag, ".bus_be"}, 32'(busa.be), 32'(e_be));
                check({tag, ".bus_we"}, 32'(busa.we), 32'(we));
                if (we) check({tag, ".bus_wdata"}, busa.wdata, e_wdata);
                if (busc == delay + 1) busa.ready = 1'b1;
            end
        end
        busa.ready = 1'b0;
        check({tag, ".done_seen"}, 32'(done), 32'd1);
        if (got) begin
            check({tag, ".bus_cycles"}, busc, exp_busc);
            check({tag, ".stall_cycles"}, stalls, exp_busc + 1);
            check({tag, ".done_cycle"}, cyc, exp_busc + 1);
            check({tag, ".stall_in_done"}, 32'(stall_req), 32'd0);
            check({tag, ".valid_in_done"}, 32'(busa.valid), 32'd0);
            check({tag, ".sb_depth"}, sb.size(), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, ".rdata_out"}, rdata_out, e.rdata);
                check({tag, ".access_fault"}, 32'(access_fault), 32'(e.fault));
                check({tag, ".fault_misalign"}, 32'(fault_misalign), 32'(e.mis));
            end
            // The request stays up through DONE; it must not start a second access.
            @(negedge clk);
            check({tag, ".done_pulse"}, 32'(done), 32'd0);
            check({tag, ".no_recapture"}, 32'(busa.valid), 32'd0);
            check({tag, ".fault_clear"}, 32'(access_fault), 32'd0);
        end
        req_valid = 1'b0;
        sb.delete();
    endtask

    initial begin
        int  vcnt;
        bit  got;
        reset       = 1'b1;
        req_valid   = 1'b1;
        req_valid_b = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = '0;
        req_wdata   = '0;
        busa.ready  = 1'b0;
        busa.rdata  = '0;
        busa.err    = 1'b0;
        busb.ready  = 1'b0;
        busb.rdata  = '0;
        busb.err    = 1'b0;

        // Reset state. stall_req follows req_valid while reset is held.
        @(negedge clk);
        check("rst.stall_follows", 32'(stall_req), 32'd1);
        req_valid = 1'b0;
        #1;
        check("rst.stall_low", 32'(stall_req), 32'd0);
        check("rst.bus_valid", 32'(busa.valid), 32'd0);
        check("rst.bus_we", 32'(busa.we), 32'd0);
        check("rst.bus_addr", busa.addr, 32'd0);
        check("rst.bus_be", 32'(busa.be), 32'd0);
        check("rst.bus_wdata", busa.wdata, 32'd0);
        check("rst.rdata_out", rdata_out, 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.fault", 32'(access_fault), 32'd0);
        check("rst.misalign", 32'(fault_misalign), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //      tag       we    f3      addr          wdata         dly brdata        err  bus
        //      e_addr        e_be     e_wdata       e_rdata       flt  mis
        access("sw",    1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0, 1'b1,
               32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        access("sb",    1'b1, 3'b000, 32'h203, 32'h000000A5, 0, 32'h0, 1'b0, 1'b1,
               32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        access("lb",    1'b0, 3'b000, 32'h301, 32'h0, 0, 32'h1234F600, 1'b0, 1'b1,
               32'h300, 4'b0010, 32'h0, 32'hFFFFFFF6, 1'b0, 1'b0);
        access("lbu",   1'b0, 3'b100, 32'h301, 32'h0, 0, 32'h1234F600, 1'b0, 1'b1,
               32'h300, 4'b0010, 32'h0, 32'h000000F6, 1'b0, 1'b0);
        access("lh_slow", 1'b0, 3'b001, 32'h402, 32'h0, 4, 32'h8001ABCD, 1'b0, 1'b1,
               32'h400, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
        access("lhu",   1'b0, 3'b101, 32'h402, 32'h0, 0, 32'h8001ABCD, 1'b0, 1'b1,
               32'h400, 4'b1100, 32'h0, 32'h00008001, 1'b0, 1'b0);
        access("ill_ld", 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h0, 1'b0, 1'b0,
               32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0);
        access("lw",    1'b0, 3'b010, 32'h700, 32'h0, 1, 32'hCAFEF00D, 1'b0, 1'b1,
               32'h700, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        access("sh",    1'b1, 3'b001, 32'h802, 32'hABCD1234, 0, 32'h0, 1'b0, 1'b1,
               32'h800, 4'b1100, 32'h12341234, 32'hCAFEF00D, 1'b0, 1'b0);
        access("ill_st", 1'b1, 3'b100, 32'h20, 32'h0, 0, 32'h0, 1'b0, 1'b0,
               32'h0, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        access("lw_err", 1'b0, 3'b010, 32'h704, 32'h0, 0, 32'h55555555, 1'b1, 1'b1,
               32'h704, 4'b1111, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        access("lw_mis", 1'b0, 3'b010, 32'h502, 32'h0, 0, 32'h11223344, 1'b0, 1'b0,
               32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
        access("lh_mis", 1'b0, 3'b001, 32'h403, 32'h0, 0, 32'h8001ABCD, 1'b0, 1'b0,
               32'h0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b1);
`else
        access("lw_mis", 1'b0, 3'b010, 32'h502, 32'h0, 0, 32'h11223344, 1'b0, 1'b1,
               32'h500, 4'b1111, 32'h0, 32'h11223344, 1'b0, 1'b0);
        access("lh_mis", 1'b0, 3'b001, 32'h403, 32'h0, 0, 32'h8001ABCD, 1'b0, 1'b1,
               32'h400, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 1'b0);
`endif

        // Timeout on the TIMEOUT_CYCLES=4 instance: four BUS cycles, then a fault.
        req_we      = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = 32'h600;
        req_valid_b = 1'b1;
        vcnt        = 0;
        got         = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (done_b) got = 1;
            else if (busb.valid) vcnt++;
        end
        check("to.done", 32'(done_b), 32'd1);
        check("to.valid_cycles", vcnt, 32'd4);
        check("to.fault", 32'(fault_b), 32'd1);
        check("to.misalign", 32'(mis_b), 32'd0);
        check("to.valid_dropped", 32'(busb.valid), 32'd0);
        check("to.stall_in_done", 32'(stall_b), 32'd0);
        @(negedge clk);
        req_valid_b = 1'b0;
        check("to.done_pulse", 32'(done_b), 32'd0);

        // Reset in the middle of a bus access.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h900;
        busa.ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid.in_bus", 32'(busa.valid), 32'd1);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("rstmid.valid_drop", 32'(busa.valid), 32'd0);
        check("rstmid.idle", 32'(stall_req), 32'd0);
        check("rstmid.done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstmid.still_idle", 32'(busa.valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
